// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame builder.
//   frame_state_t : framing FSM states
//   SYNC0/SYNC1   : the two sync bytes that open every frame header
//   HDR_LEN       : header length in bytes (2 sync + 16-bit sequence number)
//   hdr_byte()    : header byte selected by its index within the header
package adc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } frame_state_t;

    localparam logic [7:0] SYNC0   = 8'hA5;
    localparam logic [7:0] SYNC1   = 8'h5A;
    localparam int         HDR_LEN = 4;

    // Header byte for position idx; the sequence number goes out MSB first.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] seq);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC0;
            2'd1:    b = SYNC1;
            2'd2:    b = seq[15:8];
            default: b = seq[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO.
//   clk, rstn : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/din : write a byte; ignored while full
//   rd_en     : pop the head byte; ignored while empty
//   dout      : head byte, valid whenever empty is low
//   empty/full/level : occupancy status, level counts stored bytes
module byte_fifo #(
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [7:0]               din,
    input  logic                     rd_en,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          do_wr_s;
    logic          do_rd_s;

    assign empty   = (level_r == (AW+1)'(0));
    assign full    = (level_r == (AW+1)'(DEPTH));
    assign level   = level_r;
    assign do_wr_s = wr_en & ~full;
    assign do_rd_s = rd_en & ~empty;
    // Asynchronous read of the head entry gives the fall-through behaviour.
    assign dout    = mem_r[rd_ptr_r];

    // Storage array write port (no reset: contents are don't-care while empty).
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_builder.sv
// Frames the un-stallable ADC byte stream into header+payload packets on a
// byte-wide valid/ready stream.
//   clk, rstn          : clock, asynchronous active-low reset
//   din, din_valid     : incoming ADC bytes (no backpressure)
//   m_tdata/m_tvalid/m_tready/m_tlast : outgoing frame stream
//   overflow           : sticky, a byte was dropped on a full FIFO
//   seq_num            : sequence number of the next frame to start
// A frame is only started once a full payload is buffered, so the payload
// never starves mid-frame.
module adc_frame_builder
    import adc_frame_pkg::*;
#(
    parameter int PAYLOAD_LEN = 1024,
    parameter int FIFO_DEPTH  = 2048
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        overflow,
    output logic [15:0] seq_num
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(PAYLOAD_LEN);

    frame_state_t  state_r, state_s;
    logic [1:0]    hdr_idx_r, hdr_idx_s;
    logic [CW-1:0] pay_cnt_r, pay_cnt_s;
    logic [15:0]   hdr_seq_r, hdr_seq_s;
    logic [15:0]   seq_num_r, seq_num_s;
    logic [7:0]    tdata_r, tdata_s;
    logic          tvalid_r, tvalid_s;
    logic          tlast_r, tlast_s;
    logic          overflow_r, overflow_s;

    logic          wr_en_s;
    logic          rd_en_s;
    logic          hs_s;
    logic [7:0]    fifo_dout_s;
    logic          empty_s;
    logic          full_s;
    logic [LW-1:0] level_s;

    assign wr_en_s = din_valid & ~full_s;
    assign hs_s    = tvalid_r & m_tready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (wr_en_s),
        .din   (din),
        .rd_en (rd_en_s),
        .dout  (fifo_dout_s),
        .empty (empty_s),
        .full  (full_s),
        .level (level_s)
    );

    // Next-state and next-output logic. The output byte register only changes
    // on a handshake (or when idle), which keeps data stable under a stall.
    // Each payload byte is popped from the FIFO as it is loaded into m_tdata.
    always_comb begin
        state_s    = state_r;
        hdr_idx_s  = hdr_idx_r;
        pay_cnt_s  = pay_cnt_r;
        hdr_seq_s  = hdr_seq_r;
        seq_num_s  = seq_num_r;
        tdata_s    = tdata_r;
        tvalid_s   = tvalid_r;
        tlast_s    = tlast_r;
        rd_en_s    = 1'b0;
        overflow_s = overflow_r | (din_valid & full_s);

        case (state_r)
            IDLE: begin
                if (level_s >= LW'(PAYLOAD_LEN)) begin
                    state_s   = HDR;
                    tvalid_s  = 1'b1;
                    tdata_s   = SYNC0;
                    tlast_s   = 1'b0;
                    hdr_idx_s = 2'd0;
                    hdr_seq_s = seq_num_r;
                end else begin
                    tvalid_s  = 1'b0;
                    tlast_s   = 1'b0;
                end
            end
            HDR: begin
                if (hs_s) begin
                    if (hdr_idx_r == 2'(HDR_LEN - 1)) begin
                        state_s   = PAYLOAD;
                        tdata_s   = fifo_dout_s;
                        rd_en_s   = ~empty_s;
                        pay_cnt_s = '0;
                        tlast_s   = 1'b0;
                    end else begin
                        hdr_idx_s = hdr_idx_r + 2'd1;
                        tdata_s   = hdr_byte(hdr_idx_r + 2'd1, hdr_seq_r);
                    end
                end else begin
                    state_s = HDR;
                end
            end
            PAYLOAD: begin
                if (hs_s) begin
                    if (pay_cnt_r == CW'(PAYLOAD_LEN - 1)) begin
                        state_s   = IDLE;
                        tvalid_s  = 1'b0;
                        tlast_s   = 1'b0;
                        seq_num_s = seq_num_r + 16'd1;
                    end else begin
                        pay_cnt_s = pay_cnt_r + 1'b1;
                        tdata_s   = fifo_dout_s;
                        rd_en_s   = ~empty_s;
                        tlast_s   = (pay_cnt_r == CW'(PAYLOAD_LEN - 2));
                    end
                end else begin
                    state_s = PAYLOAD;
                end
            end
            default: begin
                state_s  = IDLE;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            hdr_idx_r  <= 2'd0;
            pay_cnt_r  <= '0;
            hdr_seq_r  <= 16'h0000;
            seq_num_r  <= 16'h0000;
            tdata_r    <= 8'h00;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            hdr_idx_r  <= hdr_idx_s;
            pay_cnt_r  <= pay_cnt_s;
            hdr_seq_r  <= hdr_seq_s;
            seq_num_r  <= seq_num_s;
            tdata_r    <= tdata_s;
            tvalid_r   <= tvalid_s;
            tlast_r    <= tlast_s;
            overflow_r <= overflow_s;
        end
    end

    assign m_tdata  = tdata_r;
    assign m_tvalid = tvalid_r;
    assign m_tlast  = tlast_r;
    assign overflow = overflow_r;
    assign seq_num  = seq_num_r;

endmodule

// File: tb/tb_adc_frame_builder.sv
// Directed self-checking bench for adc_frame_builder (PAYLOAD_LEN=12, FIFO_DEPTH=32).
module tb_adc_frame_builder;
    localparam int PL = 12;
    localparam int FD = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        m_tready = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        overflow;
    logic [15:0] seq_num;

    int checks = 0;
    int errors = 0;
    int stall_viol = 0;

    logic [8:0]  q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_last = 1'b0;

    adc_frame_builder #(
        .PAYLOAD_LEN (PL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .din_valid (din_valid),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .overflow  (overflow),
        .seq_num   (seq_num)
    );

    always #4 clk = ~clk;

    // Capture handshaken bytes and watch that stalled outputs hold steady.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
                stall_viol++;
            if (m_tvalid && m_tready)
                q.push_back({m_tlast, m_tdata});
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int n, input int budget, input bit rnd);
        int k = 0;
        while (q.size() < n && k < budget) begin
            if (rnd) m_tready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        chk(tag, 32'(q.size() >= n), 32'd1);
    endtask

    function automatic logic [7:0] dpat(input int i);
        return 8'(i * 5 + 16);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tvalid"},   32'(m_tvalid),      32'd0);
        chk({tag, "_tlast"},    32'(m_tlast),       32'd0);
        chk({tag, "_tdata"},    32'(m_tdata),       32'h00);
        chk({tag, "_overflow"}, 32'(overflow),      32'd0);
        chk({tag, "_seq"},      32'(seq_num),       32'h0000);
        chk({tag, "_level"},    32'(dut.level_s),   32'd0);
    endtask

    initial begin
        logic [8:0] exp_e;

        // ---- reset state ----
        rstn = 1'b0;
        #1;
        chk_reset_vals("rst");
        tick();
        tick();
        rstn     = 1'b1;
        m_tready = 1'b1;

        // ---- 11 bytes hold off the frame; the 12th starts it ----
        q.delete();
        for (int i = 0; i < 11; i++) push(8'(i));
        for (int i = 0; i < 5; i++) tick();
        chk("short_tvalid", 32'(m_tvalid), 32'd0);
        chk("short_noout", 32'(q.size()), 32'd0);
        push(8'h0B);
        chk("start_lat1_tvalid", 32'(m_tvalid), 32'd0);
        tick();
        chk("start_lat2_tvalid", 32'(m_tvalid), 32'd1);
        chk("start_lat2_tdata", 32'(m_tdata), 32'hA5);
        for (int i = 0; i < 15; i++) tick();
        chk("last_cycle_tvalid", 32'(m_tvalid), 32'd1);
        chk("last_cycle_tlast", 32'(m_tlast), 32'd1);
        chk("last_cycle_tdata", 32'(m_tdata), 32'h0B);
        tick();
        chk("after_frame_tvalid", 32'(m_tvalid), 32'd0);
        chk("t1_count", 32'(q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       exp_e = 9'h0A5;
                1:       exp_e = 9'h05A;
                2:       exp_e = 9'h000;
                3:       exp_e = 9'h000;
                default: exp_e = {(i == 15) ? 1'b1 : 1'b0, 8'(i - 4)};
            endcase
            if (i < q.size()) chk($sformatf("t1_byte%0d", i), 32'(q[i]), 32'(exp_e));
        end
        chk("t1_seq", 32'(seq_num), 32'h0001);

        // ---- random backpressure across three frames ----
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        q.delete();
        m_tready = 1'b0;
        for (int i = 0; i < 12; i++) push(dpat(i));
        for (int i = 12; i < 36; i++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            push(dpat(i));
            m_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        wait_q("rnd_done", 48, 1000, 1'b1);
        m_tready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 16; j++) begin
                case (j)
                    0:       exp_e = 9'h0A5;
                    1:       exp_e = 9'h05A;
                    2:       exp_e = 9'h000;
                    3:       exp_e = {1'b0, 8'(f)};
                    default: exp_e = {(j == 15) ? 1'b1 : 1'b0, dpat(12 * f + j - 4)};
                endcase
                if (16 * f + j < q.size())
                    chk($sformatf("rnd_f%0d_b%0d", f, j), 32'(q[16 * f + j]), 32'(exp_e));
            end
        end
        chk("rnd_stable", 32'(stall_viol), 32'd0);
        chk("rnd_seq", 32'(seq_num), 32'h0003);
        chk("rnd_no_overflow", 32'(overflow), 32'd0);

        // ---- sequence number wrap ----
        q.delete();
        force dut.seq_num_r = 16'hFFFF;
        tick();
        chk("wrap_preset", 32'(seq_num), 32'hFFFF);
        for (int i = 0; i < 24; i++) push(8'(8'hC0 + i));
        wait_q("wrap_hdr", 4, 200, 1'b0);
        release dut.seq_num_r;
        wait_q("wrap_done", 32, 500, 1'b0);
        if (q.size() >= 32) begin
            chk("wrap_h1_hi", 32'(q[2]),  32'h0FF);
            chk("wrap_h1_lo", 32'(q[3]),  32'h0FF);
            chk("wrap_h1_p0", 32'(q[4]),  32'h0C0);
            chk("wrap_h2_hi", 32'(q[18]), 32'h000);
            chk("wrap_h2_lo", 32'(q[19]), 32'h000);
            chk("wrap_h2_last", 32'(q[31]), 32'h1D7);
        end
        chk("wrap_seq", 32'(seq_num), 32'h0001);

        // ---- overflow with the sink stalled ----
        q.delete();
        m_tready = 1'b0;
        for (int i = 0; i < 32; i++) push(8'(8'h40 + i));
        chk("ovf_full_noflag", 32'(overflow), 32'd0);
        chk("ovf_full_level", 32'(dut.level_s), 32'd32);
        push(8'h60);
        chk("ovf_flag_next", 32'(overflow), 32'd1);
        for (int i = 1; i < 8; i++) push(8'(8'h60 + i));
        tick();
        chk("ovf_level", 32'(dut.level_s), 32'd32);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_stall_tvalid", 32'(m_tvalid), 32'd1);
        chk("ovf_stall_tdata", 32'(m_tdata), 32'hA5);
        m_tready = 1'b1;
        wait_q("ovf_frame", 16, 200, 1'b0);
        if (q.size() >= 16) begin
            chk("ovf_hdr_hi", 32'(q[2]), 32'h000);
            chk("ovf_hdr_lo", 32'(q[3]), 32'h001);
            for (int j = 0; j < 12; j++)
                chk($sformatf("ovf_p%0d", j), 32'(q[4 + j]),
                    32'({(j == 11) ? 1'b1 : 1'b0, 8'(8'h40 + j)}));
        end

        // ---- asynchronous reset in the middle of a payload ----
        wait_q("mid_reach", 23, 200, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        rstn = 1'b1;
        q.delete();
        for (int i = 0; i < 12; i++) push(8'(8'h80 + i));
        wait_q("post_rst_frame", 16, 200, 1'b0);
        if (q.size() >= 16) begin
            chk("post_sync0", 32'(q[0]),  32'h0A5);
            chk("post_sync1", 32'(q[1]),  32'h05A);
            chk("post_hi",    32'(q[2]),  32'h000);
            chk("post_lo",    32'(q[3]),  32'h000);
            chk("post_p0",    32'(q[4]),  32'h080);
            chk("post_last",  32'(q[15]), 32'h18B);
        end
        chk("post_seq", 32'(seq_num), 32'h0001);
        chk("final_stable", 32'(stall_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
